// File: rtl/arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Holds the arbiter state encoding and the default fetch-starvation limit.
package arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_F = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_F = 3'd3,
        ST_RESP_D = 3'd4
    } arb_state_e;

    localparam int unsigned STARVE_MAX_DEF = 3;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between the fetch and data stages.
// Data normally wins; fetch is forced through after STARVE_MAX data grants.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    localparam logic [2:0] STARVE_MAX_L = 3'(STARVE_MAX);

    arb_state_e  state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic        drop_q, drop_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        m_we_q, m_we_d;
    logic        fetch_win;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= STARVE_MAX_L) ? v : v + 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= 3'd0;
            drop_q      <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            m_addr_q    <= 32'd0;
            m_wdata_q   <= 32'd0;
            m_we_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_we_q      <= m_we_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        drop_d      = drop_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_we_d      = m_we_q;
        fetch_win   = if_req && (!mem_req || (starve_q == STARVE_MAX_L));

        unique case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (fetch_win) begin
                    state_d  = ST_BUSY_F;
                    m_addr_d = if_addr;
                    m_we_d   = 1'b0;
                    starve_d = 3'd0;
                end else if (mem_req) begin
                    state_d   = ST_BUSY_D;
                    m_addr_d  = mem_addr;
                    m_wdata_d = mem_wdata;
                    m_we_d    = mem_we;
                    if (if_req) begin
                        starve_d = sat_inc(starve_q);
                    end
                end
            end
            ST_BUSY_F: begin
                // A redirect cannot abort the memory; the result is just discarded.
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                if (m_ready) begin
                    if_rdata_d = m_rdata;
                    state_d    = ST_RESP_F;
                end
            end
            ST_BUSY_D: begin
                if (m_ready) begin
                    mem_rdata_d = m_rdata;
                    state_d     = ST_RESP_D;
                end
            end
            ST_RESP_F, ST_RESP_D: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_req     = (state_q == ST_BUSY_F) || (state_q == ST_BUSY_D);
    assign m_we      = (state_q == ST_BUSY_D) && m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_valid  = (state_q == ST_RESP_F) && !drop_q && !if_flush;
    assign mem_done  = (state_q == ST_RESP_D);
    assign if_stall  = if_req && !if_valid;
    assign mem_stall = mem_req && !mem_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a reactive memory model whose
// read data is address ^ KEY and whose ready latency is set per scenario.
module tb_unified_mem_arbiter;
    import arb_pkg::*;

    localparam logic [31:0] KEY = 32'h0050_0193;

    logic        clk, rst;
    logic        if_req, if_flush, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_done, mem_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        m_req, m_we, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int checks = 0;
    int failures = 0;
    int delay = 0;
    int mcnt = 0;

    unified_mem_arbiter #(.STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_stall(mem_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory completes after 'delay' extra cycles of m_req.
    assign m_ready = m_req && (mcnt == delay);
    assign m_rdata = m_addr ^ KEY;
    always @(posedge clk) mcnt <= (m_req && !m_ready) ? mcnt + 1 : 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_flush = 1'b0; mem_we = 1'b0; mem_wdata = 32'd0;
        if_req = 1'b1; if_addr = 32'h100; mem_req = 1'b1; mem_addr = 32'h2000;
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset.m_req c=%0d got=%0b exp=0", c, m_req); end
            checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset.if_valid c=%0d got=%0b exp=0", c, if_valid); end
            checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL reset.mem_done c=%0d got=%0b exp=0", c, mem_done); end
            checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL reset.m_we c=%0d got=%0b exp=0", c, m_we); end
            checks++; if (m_addr !== 32'd0) begin failures++; $display("FAIL reset.m_addr c=%0d got=%h exp=0", c, m_addr); end
            checks++; if (m_wdata !== 32'd0) begin failures++; $display("FAIL reset.m_wdata c=%0d got=%h exp=0", c, m_wdata); end
            checks++; if (if_rdata !== 32'd0) begin failures++; $display("FAIL reset.if_rdata c=%0d got=%h exp=0", c, if_rdata); end
            checks++; if (mem_rdata !== 32'd0) begin failures++; $display("FAIL reset.mem_rdata c=%0d got=%h exp=0", c, mem_rdata); end
            checks++; if (if_stall !== 1'b1) begin failures++; $display("FAIL reset.if_stall c=%0d got=%0b exp=1", c, if_stall); end
            @(posedge clk); #1;
        end
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        apply_reset();
        delay = 1;
        for (int c = 0; c <= 4; c++) begin
            if_req = (c <= 3); if_addr = 32'h100;
            @(negedge clk);
            checks++; if (m_req !== (c == 1 || c == 2)) begin failures++; $display("FAIL fetch.m_req c=%0d got=%0b", c, m_req); end
            checks++; if (if_valid !== (c == 3)) begin failures++; $display("FAIL fetch.if_valid c=%0d got=%0b", c, if_valid); end
            checks++; if (if_stall !== (c <= 2)) begin failures++; $display("FAIL fetch.if_stall c=%0d got=%0b", c, if_stall); end
            if (c == 1) begin
                checks++; if (m_addr !== 32'h100) begin failures++; $display("FAIL fetch.m_addr got=%h exp=00000100", m_addr); end
                checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL fetch.m_we got=%0b exp=0", m_we); end
            end
            if (c == 3) begin
                checks++; if (if_rdata !== 32'h0050_0093) begin failures++; $display("FAIL fetch.if_rdata got=%h exp=00500093", if_rdata); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        apply_reset();
        delay = 0;
        for (int c = 0; c <= 6; c++) begin
            if_req = (c <= 5); if_addr = 32'h104;
            mem_req = (c <= 2); mem_we = 1'b0; mem_addr = 32'h2000;
            @(negedge clk);
            checks++; if (m_req !== (c == 1 || c == 4)) begin failures++; $display("FAIL contend.m_req c=%0d got=%0b", c, m_req); end
            checks++; if (mem_done !== (c == 2)) begin failures++; $display("FAIL contend.mem_done c=%0d got=%0b", c, mem_done); end
            checks++; if (if_valid !== (c == 5)) begin failures++; $display("FAIL contend.if_valid c=%0d got=%0b", c, if_valid); end
            checks++; if (if_stall !== (c <= 4)) begin failures++; $display("FAIL contend.if_stall c=%0d got=%0b", c, if_stall); end
            checks++; if (mem_stall !== (c <= 1)) begin failures++; $display("FAIL contend.mem_stall c=%0d got=%0b", c, mem_stall); end
            if (c == 1) begin
                checks++; if (m_addr !== 32'h2000) begin failures++; $display("FAIL contend.m_addr_d got=%h exp=00002000", m_addr); end
            end
            if (c == 4) begin
                checks++; if (m_addr !== 32'h104) begin failures++; $display("FAIL contend.m_addr_f got=%h exp=00000104", m_addr); end
            end
            if (c == 2) begin
                checks++; if (mem_rdata !== 32'h0050_2193) begin failures++; $display("FAIL contend.mem_rdata got=%h exp=00502193", mem_rdata); end
            end
            if (c == 5) begin
                checks++; if (if_rdata !== 32'h0050_0097) begin failures++; $display("FAIL contend.if_rdata got=%h exp=00500097", if_rdata); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_starvation();
        apply_reset();
        delay = 0;
        for (int c = 0; c <= 17; c++) begin
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000;
            if_req = (c <= 11) || (c >= 15); if_addr = 32'h104;
            @(negedge clk);
            checks++; if (m_req !== (c % 3 == 1)) begin failures++; $display("FAIL starve.m_req c=%0d got=%0b", c, m_req); end
            checks++; if (mem_done !== (c inside {2, 5, 8, 14, 17})) begin failures++; $display("FAIL starve.mem_done c=%0d got=%0b", c, mem_done); end
            checks++; if (if_valid !== (c == 11)) begin failures++; $display("FAIL starve.if_valid c=%0d got=%0b", c, if_valid); end
            if (c % 3 == 1) begin
                checks++;
                if (m_addr !== ((c == 10) ? 32'h104 : 32'h2000)) begin
                    failures++; $display("FAIL starve.m_addr c=%0d got=%h exp=%h", c, m_addr, (c == 10) ? 32'h104 : 32'h2000);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        apply_reset();
        delay = 2;
        for (int c = 0; c <= 10; c++) begin
            if_req = (c <= 9); if_addr = (c <= 2) ? 32'h100 : 32'h200; if_flush = (c == 2);
            @(negedge clk);
            checks++; if (m_req !== (c inside {1, 2, 3, 6, 7, 8})) begin failures++; $display("FAIL flush.m_req c=%0d got=%0b", c, m_req); end
            checks++; if (if_valid !== (c == 9)) begin failures++; $display("FAIL flush.if_valid c=%0d got=%0b", c, if_valid); end
            if (c == 3 || c == 7) begin
                checks++;
                if (m_addr !== ((c == 3) ? 32'h100 : 32'h200)) begin
                    failures++; $display("FAIL flush.m_addr c=%0d got=%h exp=%h", c, m_addr, (c == 3) ? 32'h100 : 32'h200);
                end
            end
            if (c == 4) begin
                checks++; if (if_stall !== 1'b1) begin failures++; $display("FAIL flush.if_stall got=%0b exp=1", if_stall); end
            end
            if (c == 9) begin
                checks++; if (if_rdata !== 32'h0050_0393) begin failures++; $display("FAIL flush.if_rdata got=%h exp=00500393", if_rdata); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        apply_reset();
        delay = 2;
        for (int c = 0; c <= 6; c++) begin
            mem_req = (c <= 4); mem_we = 1'b1; mem_addr = 32'h3000; mem_wdata = 32'hDEAD_BEEF;
            @(negedge clk);
            checks++; if (m_req !== (c >= 1 && c <= 3)) begin failures++; $display("FAIL store.m_req c=%0d got=%0b", c, m_req); end
            checks++; if (m_we !== (c >= 1 && c <= 3)) begin failures++; $display("FAIL store.m_we c=%0d got=%0b", c, m_we); end
            checks++; if (mem_done !== (c == 4)) begin failures++; $display("FAIL store.mem_done c=%0d got=%0b", c, mem_done); end
            checks++; if (mem_stall !== (c <= 3)) begin failures++; $display("FAIL store.mem_stall c=%0d got=%0b", c, mem_stall); end
            if (c >= 1 && c <= 3) begin
                checks++; if (m_addr !== 32'h3000) begin failures++; $display("FAIL store.m_addr c=%0d got=%h exp=00003000", c, m_addr); end
                checks++; if (m_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store.m_wdata c=%0d got=%h exp=deadbeef", c, m_wdata); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_busy();
        apply_reset();
        delay = 5;
        for (int c = 0; c <= 5; c++) begin
            mem_req = (c <= 2); mem_we = 1'b0; mem_addr = 32'h2000; rst = (c == 2);
            @(negedge clk);
            checks++; if (m_req !== (c == 1 || c == 2)) begin failures++; $display("FAIL rstbusy.m_req c=%0d got=%0b", c, m_req); end
            checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL rstbusy.mem_done c=%0d got=%0b exp=0", c, mem_done); end
            if (c == 3) begin
                checks++; if (m_addr !== 32'd0) begin failures++; $display("FAIL rstbusy.m_addr got=%h exp=0", m_addr); end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_contention();
        test_starvation();
        test_flush();
        test_store();
        test_reset_in_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 3, consecutive data grants with fetch waiting before fetch is forced a grant (range 1..7).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch stage requests an instruction read; held until if_valid or if_flush.
REQ-005 if_addr  input  32  fetch address; stable while if_req is high.
REQ-006 if_flush  input  1  branch redirect (PCSrcE); any outstanding fetch result is discarded.
REQ-007 if_rdata  output  32  fetched instruction; meaningful only when if_valid is high.
REQ-008 if_valid  output  1  one-cycle pulse: fetch complete.
REQ-009 if_stall  output  1  if_req and not if_valid; ORed into StallF/StallD by the pipeline.
REQ-010 mem_req, mem_we  input  1 each  data-stage access request and write enable; held until mem_done.
REQ-011 mem_addr, mem_wdata  input  32 each  data address and store data.
REQ-012 mem_rdata  output  32  load data; meaningful only when mem_done is high.
REQ-013 mem_done  output  1  one-cycle pulse: data access complete.
REQ-014 mem_stall  output  1  mem_req and not mem_done; stalls F/D/E/M.
REQ-015 m_req, m_we  output  1 each  request and write enable to the single-port memory.
REQ-016 m_addr, m_wdata  output  32 each  memory address and write data, driven from internal registers.
REQ-017 m_ready  input  1  memory completes the current access this cycle.
REQ-018 m_rdata  input  32  read data, valid when m_ready is high.

Function
REQ-019 FSM states: IDLE, BUSY_F, BUSY_D, RESP_F, RESP_D.
REQ-020 IDLE: if either request is high, latch the winner's addr/we/wdata into registers and go to BUSY_F or BUSY_D next cycle.
REQ-021 Priority: data beats fetch, unless starve_cnt == STARVE_MAX and if_req is high, in which case fetch wins.
REQ-022 starve_cnt (3 bits): +1 on a data grant while if_req is high, saturating at STARVE_MAX; cleared on any fetch grant.
REQ-023 BUSY_x: m_req = 1 with registered outputs held stable. On m_ready: capture m_rdata, go to RESP_x. Otherwise stay.
REQ-024 BUSY_F always drives m_we = 0. BUSY_D drives the latched mem_we.
REQ-025 RESP_F: if_valid = 1 unless drop or if_flush is high. RESP_D: mem_done = 1. Both states always go to IDLE.
REQ-026 Minimum access latency: request seen in IDLE at cycle N, m_req at N+1, done/valid pulse at N+1+k where k is the number of BUSY cycles (k >= 1).
REQ-027 A request is never re-arbitrated during the RESP cycle, so there is no double service.
REQ-028 Flush: if_flush in BUSY_F sets drop. The memory access completes normally, but RESP_F gives no if_valid. drop clears on entry to IDLE.
REQ-029 Flush in IDLE, BUSY_D or RESP_D has no effect.
REQ-030 Flush does not cancel m_req; memory transactions are never aborted except by reset.
REQ-031 Stores (mem_we = 1) return mem_done with mem_rdata don't-care.
REQ-032 m_req is 0 in IDLE and RESP states. Outputs are driven from state and registers only, except if_stall and mem_stall (which use combinational req terms).

Reset
REQ-033 On rst: state = IDLE, starve_cnt = 0, drop = 0, if_rdata = 0, mem_rdata = 0, m_addr = 0, m_wdata = 0, m_we = 0.
REQ-034 On rst: m_req, if_valid and mem_done are 0 the cycle after rst is sampled.
REQ-035 Reset during BUSY_x abandons the access. The memory shall tolerate m_req dropping without m_ready.

Structure
REQ-036 Shared package arb_pkg holds the state enum and the STARVE_MAX default.
REQ-037 Single module; no sub-module is needed.

Verification
REQ-038 Fetch only, addr 0x100, m_ready asserted 1 cycle after m_req, m_rdata 0x00500093 -> if_valid with if_rdata 0x00500093 at cycle 3; if_stall high cycles 0-2.
REQ-039 if_req and mem_req (load 0x2000) raised in the same cycle -> data served first (mem_done), then fetch; if_stall held throughout.
REQ-040 Continuous data requests with if_req held, STARVE_MAX = 3 -> the 4th grant goes to fetch; starve_cnt returns to 0.
REQ-041 if_flush pulsed during BUSY_F -> m_req completes, no if_valid, return to IDLE, new if_addr 0x200 served next.
REQ-042 Store 0x3000 / 0xDEADBEEF with 3-cycle m_ready delay -> m_we = 1, stable addr/data for 3 cycles, mem_done pulse once.
REQ-043 rst asserted in BUSY_D -> m_req = 0 next cycle, state IDLE, no mem_done.
